// File: rtl/axis_counter_source_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_counter_source_if
// Purpose  : AXI-Stream bundle driven by axis_counter_source. The tuser field
//            exists only when AXIS_SRC_TUSER_EN is defined.
// Revision : 1.0
// ============================================================================
interface axis_counter_source_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
`ifdef AXIS_SRC_TUSER_EN
    logic [7:0]            tuser;
`endif

    modport master (
        input  tready,
`ifdef AXIS_SRC_TUSER_EN
        output tuser,
`endif
        output tvalid,
        output tdata,
        output tlast
    );

    modport slave (
        output tready,
`ifdef AXIS_SRC_TUSER_EN
        input  tuser,
`endif
        input  tvalid,
        input  tdata,
        input  tlast
    );
endinterface
`default_nettype wire

// File: rtl/axis_counter_source.sv
`default_nettype none
// ============================================================================
// Module   : axis_counter_source
// Purpose  : AXI-Stream master emitting packets of incrementing counter
//            values. Optional AXIS_SRC_TUSER_EN adds tuser = packet index.
// Revision : 1.0
// ============================================================================
module axis_counter_source #(
    parameter int          DATA_WIDTH    = 16,
    parameter logic [63:0] START_VALUE   = 64'd800,
    parameter logic [63:0] END_VALUE     = 64'd808,
    parameter logic [63:0] STEP          = 64'd1,
    parameter int          GAP_CYCLES    = 0,
    parameter int          PKT_CNT_WIDTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     enable,
    input  wire logic [PKT_CNT_WIDTH-1:0] num_packets,
    axis_counter_source_if.master         m,
    output logic                          busy,
    output logic                          done,
    output logic [PKT_CNT_WIDTH-1:0]      pkt_count
);

    localparam logic [DATA_WIDTH-1:0]    c_start    = START_VALUE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH:0]      c_end      = {1'b0, END_VALUE[DATA_WIDTH-1:0]};
    localparam logic [DATA_WIDTH:0]      c_step     = {1'b0, STEP[DATA_WIDTH-1:0]};
    localparam bit                       c_has_gap  = (GAP_CYCLES > 0);
    localparam logic [7:0]               c_gap_load = c_has_gap ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [PKT_CNT_WIDTH-1:0] c_pkt_max  = '1;
    localparam logic [PKT_CNT_WIDTH-1:0] c_pkt_one  = PKT_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DATA_WIDTH-1:0]    r_tdata;
    logic [DATA_WIDTH-1:0]    w_tdata_next;
    logic [PKT_CNT_WIDTH-1:0] r_num_pkts;
    logic [PKT_CNT_WIDTH-1:0] w_num_next;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_count;
    logic [PKT_CNT_WIDTH-1:0] w_pkt_next;
    logic [PKT_CNT_WIDTH-1:0] w_pkt_plus1;
    logic [PKT_CNT_WIDTH-1:0] w_pkt_sat;
    logic [7:0]               r_gap_cnt;
    logic [7:0]               w_gap_next;
    logic [DATA_WIDTH:0]      w_sum;
    logic                     w_last;
    logic                     w_xfer;
`ifdef AXIS_SRC_TUSER_EN
    logic [7:0]               r_tuser;
    logic [7:0]               w_tuser_next;
`endif

    // One extra bit on the sum so a value near the top of the range cannot wrap
    assign w_sum       = {1'b0, r_tdata} + c_step;
    assign w_last      = (w_sum > c_end);
    assign w_xfer      = (r_state == S_SEND) && m.tready;
    assign w_pkt_plus1 = r_pkt_count + c_pkt_one;
    assign w_pkt_sat   = (r_pkt_count == c_pkt_max) ? r_pkt_count : w_pkt_plus1;

    always_comb begin
        w_state_next = r_state;
        w_tdata_next = r_tdata;
        w_num_next   = r_num_pkts;
        w_pkt_next   = r_pkt_count;
        w_gap_next   = r_gap_cnt;
`ifdef AXIS_SRC_TUSER_EN
        w_tuser_next = r_tuser;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_SEND;
                    w_tdata_next = c_start;
                    w_num_next   = num_packets;
                    w_pkt_next   = '0;
`ifdef AXIS_SRC_TUSER_EN
                    w_tuser_next = 8'd0;
`endif
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_tdata_next = w_sum[DATA_WIDTH-1:0];
                    end else begin
                        w_pkt_next   = w_pkt_sat;
                        w_tdata_next = c_start;
`ifdef AXIS_SRC_TUSER_EN
                        w_tuser_next = 8'(w_pkt_sat);
`endif
                        // Run limit wins over enable, which wins over the gap
                        if ((r_num_pkts != '0) && (w_pkt_plus1 == r_num_pkts)) begin
                            w_state_next = S_DONE;
                        end else if (!enable) begin
                            w_state_next = S_IDLE;
                        end else if (c_has_gap) begin
                            w_state_next = S_GAP;
                            w_gap_next   = c_gap_load;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_next = enable ? S_SEND : S_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - 8'd1;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tdata     <= '0;
            r_num_pkts  <= '0;
            r_pkt_count <= '0;
            r_gap_cnt   <= 8'd0;
`ifdef AXIS_SRC_TUSER_EN
            r_tuser     <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_tdata     <= w_tdata_next;
            r_num_pkts  <= w_num_next;
            r_pkt_count <= w_pkt_next;
            r_gap_cnt   <= w_gap_next;
`ifdef AXIS_SRC_TUSER_EN
            r_tuser     <= w_tuser_next;
`endif
        end
    end

    assign m.tvalid  = (r_state == S_SEND);
    assign m.tdata   = r_tdata;
    assign m.tlast   = (r_state == S_SEND) && w_last;
`ifdef AXIS_SRC_TUSER_EN
    assign m.tuser   = r_tuser;
`endif
    assign busy      = (r_state == S_SEND) || (r_state == S_GAP);
    assign done      = (r_state == S_DONE);
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_counter_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_counter_source
// Purpose  : Directed/random bench for axis_counter_source (default 800..808
//            instance plus a 0..10 step 3 gap 3 instance).
// Revision : 1.0
// ============================================================================
module tb_axis_counter_source;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [7:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ena_a, ena_b;
    logic [15:0] num_a, cnt_a;
    logic [3:0]  num_b, cnt_b;
    logic        busy_a, done_a, busy_b, done_b;

    axis_counter_source_if #(.DATA_WIDTH(16)) ma ();
    axis_counter_source_if #(.DATA_WIDTH(8))  mb ();

    axis_counter_source dut_a (
        .clk(clk), .reset(rst), .enable(ena_a), .num_packets(num_a),
        .m(ma), .busy(busy_a), .done(done_a), .pkt_count(cnt_a)
    );

    axis_counter_source #(
        .DATA_WIDTH(8), .START_VALUE(64'd0), .END_VALUE(64'd10), .STEP(64'd3),
        .GAP_CYCLES(3), .PKT_CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset(rst), .enable(ena_b), .num_packets(num_b),
        .m(mb), .busy(busy_b), .done(done_b), .pkt_count(cnt_b)
    );

    // Reference model parameters per instance: range walked with plain arithmetic
    longint m_start [2] = '{800, 0};
    longint m_end   [2] = '{808, 10};
    longint m_step  [2] = '{1, 3};

    beat_t q0[$];
    beat_t q1[$];
    beat_t held [2];
    logic  stall [2];
    logic  after_last [2];
    int    idle_run [2];
    int    gap_max [2];
    int    xfers [2];
    int    first_cyc [2];
    int    last_cyc [2];
    int    cycle_no = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int id, input int idx);
        for (longint v = m_start[id]; v <= m_end[id]; v += m_step[id]) begin
            beat_t b;
            b.data = 16'(v);
            b.last = (v + m_step[id] > m_end[id]);
            b.user = 8'(idx);
            if (id == 0) q0.push_back(b);
            else         q1.push_back(b);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            stall[i]      = 1'b0;
            after_last[i] = 1'b0;
            idle_run[i]   = 0;
            gap_max[i]    = -1;
            xfers[i]      = 0;
            first_cyc[i]  = -1;
            last_cyc[i]   = -1;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic observe(input int id, input logic v, input logic r,
                           input logic [15:0] d, input logic l, input logic [7:0] u);
        beat_t e;
        int    qsize;
        if (stall[id]) begin
            chk($sformatf("hold_valid%0d", id), 64'(v), 64'(1));
            chk($sformatf("hold_data%0d", id), 64'(d), 64'(held[id].data));
            chk($sformatf("hold_last%0d", id), 64'(l), 64'(held[id].last));
`ifdef AXIS_SRC_TUSER_EN
            chk($sformatf("hold_user%0d", id), 64'(u), 64'(held[id].user));
`endif
        end
        if (after_last[id]) begin
            if (v === 1'b1) begin
                if (idle_run[id] > gap_max[id]) gap_max[id] = idle_run[id];
                after_last[id] = 1'b0;
            end else begin
                idle_run[id]++;
            end
        end
        if (v === 1'b1 && r === 1'b1) begin
            if (xfers[id] == 0) first_cyc[id] = cycle_no;
            xfers[id]++;
            qsize = (id == 0) ? q0.size() : q1.size();
            chk($sformatf("beat_expected%0d", id), 64'(qsize > 0), 64'(1));
            if (qsize > 0) begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                chk($sformatf("beat_data%0d", id), 64'(d), 64'(e.data));
                chk($sformatf("beat_last%0d", id), 64'(l), 64'(e.last));
`ifdef AXIS_SRC_TUSER_EN
                chk($sformatf("beat_user%0d", id), 64'(u), 64'(e.user));
`endif
            end
            if (l === 1'b1) begin
                after_last[id] = 1'b1;
                idle_run[id]   = 0;
                last_cyc[id]   = cycle_no;
            end
            stall[id] = 1'b0;
        end else begin
            stall[id]     = (v === 1'b1);
            held[id].data = d;
            held[id].last = l;
            held[id].user = u;
        end
    endtask

    // Samples both streams at the falling edge, then returns just after the rising edge
    task automatic cyc();
        @(negedge clk);
`ifdef AXIS_SRC_TUSER_EN
        observe(0, ma.tvalid, ma.tready, ma.tdata, ma.tlast, ma.tuser);
        observe(1, mb.tvalid, mb.tready, 16'(mb.tdata), mb.tlast, mb.tuser);
`else
        observe(0, ma.tvalid, ma.tready, ma.tdata, ma.tlast, 8'd0);
        observe(1, mb.tvalid, mb.tready, 16'(mb.tdata), mb.tlast, 8'd0);
`endif
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    initial begin
        int   n;
        int   c0;
        logic done_seen;

        rst = 1'b1; ena_a = 1'b0; ena_b = 1'b0; num_a = '0; num_b = '0;
        ma.tready = 1'b0; mb.tready = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid_a", 64'(ma.tvalid), 64'(0));
        chk("rst_tdata_a",  64'(ma.tdata),  64'(0));
        chk("rst_tlast_a",  64'(ma.tlast),  64'(0));
        chk("rst_busy_a",   64'(busy_a),    64'(0));
        chk("rst_done_a",   64'(done_a),    64'(0));
        chk("rst_cnt_a",    64'(cnt_a),     64'(0));
        chk("rst_tvalid_b", 64'(mb.tvalid), 64'(0));
        chk("rst_tdata_b",  64'(mb.tdata),  64'(0));
        chk("rst_cnt_b",    64'(cnt_b),     64'(0));
        rst = 1'b0;
        cyc();

        // Single packet, always ready
        clear_mon(); push_pkt(0, 0);
        num_a = 16'd1; ma.tready = 1'b1; ena_a = 1'b1; c0 = cycle_no;
        for (n = 0; n < 40 && done_a !== 1'b1; n++) cyc();
        chk("t1_done",    64'(done_a), 64'(1));
        chk("t1_count",   64'(cnt_a), 64'(1));
        chk("t1_busy",    64'(busy_a), 64'(0));
        chk("t1_tvalid",  64'(ma.tvalid), 64'(0));
        chk("t1_beats",   64'(xfers[0]), 64'(9));
        chk("t1_left",    64'(q0.size()), 64'(0));
        chk("t1_latency", 64'(first_cyc[0]), 64'(c0 + 1));
        chk("t1_span",    64'(last_cyc[0] - first_cyc[0]), 64'(8));
        cyc();
        chk("t1_done_hold", 64'(done_a), 64'(1));
        ena_a = 1'b0; cyc();
        chk("t1_done_clr", 64'(done_a), 64'(0));

        // Single packet under random backpressure
        clear_mon(); push_pkt(0, 0);
        num_a = 16'd1; ena_a = 1'b1;
        for (n = 0; n < 200 && done_a !== 1'b1; n++) begin
            ma.tready = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("t2_done",  64'(done_a), 64'(1));
        chk("t2_count", 64'(cnt_a), 64'(1));
        chk("t2_beats", 64'(xfers[0]), 64'(9));
        chk("t2_left",  64'(q0.size()), 64'(0));
        ena_a = 1'b0; ma.tready = 1'b1; cyc();

        // Stepped range with inter-packet gap; late num_packets change must be ignored
        clear_mon(); push_pkt(1, 0); push_pkt(1, 1);
        num_b = 4'd2; ena_b = 1'b1;
        for (n = 0; n < 200 && done_b !== 1'b1; n++) begin
            mb.tready = 1'($urandom_range(0, 1));
            cyc();
            if (n == 2) num_b = 4'd5;
        end
        chk("t3_done",  64'(done_b), 64'(1));
        chk("t3_count", 64'(cnt_b), 64'(2));
        chk("t3_beats", 64'(xfers[1]), 64'(8));
        chk("t3_left",  64'(q1.size()), 64'(0));
        chk("t3_gap",   64'(gap_max[1]), 64'(3));
        ena_b = 1'b0; cyc();
        chk("t3_done_clr", 64'(done_b), 64'(0));

        // Unlimited run, enable dropped during third beat of third packet
        clear_mon();
        for (int p = 0; p < 3; p++) push_pkt(0, p);
        num_a = 16'd0; ma.tready = 1'b1; ena_a = 1'b1; done_seen = 1'b0;
        for (n = 0; n < 100 && !(xfers[0] >= 27 && busy_a === 1'b0); n++) begin
            cyc();
            if (done_a === 1'b1) done_seen = 1'b1;
            if (xfers[0] == 20) ena_a = 1'b0;
        end
        chk("t4_beats",  64'(xfers[0]), 64'(27));
        chk("t4_left",   64'(q0.size()), 64'(0));
        chk("t4_busy",   64'(busy_a), 64'(0));
        chk("t4_nodone", 64'(done_seen), 64'(0));
        chk("t4_b2b",    64'(gap_max[0]), 64'(0));
        chk("t4_count",  64'(cnt_a), 64'(3));
        cyc(); cyc();
        chk("t4_idle",   64'(xfers[0]), 64'(27));

        // Asynchronous reset in the middle of a packet
        clear_mon(); push_pkt(0, 0);
        num_a = 16'd0; ena_a = 1'b1;
        for (n = 0; n < 20 && !(ma.tvalid === 1'b1 && ma.tdata === 16'd804); n++) cyc();
        chk("t5_at_804", 64'(ma.tdata), 64'(804));
        #2 rst = 1'b1;
        #1;
        chk("t5_tvalid", 64'(ma.tvalid), 64'(0));
        chk("t5_tdata",  64'(ma.tdata), 64'(0));
        chk("t5_tlast",  64'(ma.tlast), 64'(0));
        chk("t5_busy",   64'(busy_a), 64'(0));
        chk("t5_cnt",    64'(cnt_a), 64'(0));
`ifdef AXIS_SRC_TUSER_EN
        chk("t5_tuser",  64'(ma.tuser), 64'(0));
`endif
        clear_mon(); push_pkt(0, 0);
        num_a = 16'd1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (n = 0; n < 40 && done_a !== 1'b1; n++) cyc();
        chk("t5_done",  64'(done_a), 64'(1));
        chk("t5_beats", 64'(xfers[0]), 64'(9));
        chk("t5_left",  64'(q0.size()), 64'(0));
        chk("t5_count", 64'(cnt_a), 64'(1));
        ena_a = 1'b0; cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
